exu_cordic_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one CORDIC execution unit (`exu_cordic`) among `NREQ` requesters, such as the main dispatch path and a vector/coprocessor issue port. It grants one request at a time and tracks the owner of the single outstanding operation. It routes the result back to that owner and converts a hung unit into an error response via a watchdog. It sits between the requester issue ports and the `exu_cordic` dispatch/write-back handshake.

---
 rtl/exu_cordic_arb_pkg.sv | 25 ++
 rtl/exu_cordic_arb_rr_arbiter.sv | 41 ++++
 rtl/exu_cordic_arb.sv | 149 ++++++++++++++
 tb/tb_exu_cordic_arb.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_cordic_arb_pkg.sv
// exu_cordic_arb_pkg
// Shared definitions for the CORDIC arbiter slice: FSM state encoding,
// default parameter values and a small index-width helper.
// No ports; imported by rr_arbiter and exu_cordic_arb.

package exu_cordic_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    localparam int DEFAULT_NREQ = 2;
    localparam int DEFAULT_XLEN = 32;
    localparam int DEFAULT_RIDX = 5;
    localparam int DEFAULT_TMO  = 64;

    // Width of an index selecting one of n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exu_cordic_arb_rr_arbiter.sv
// rr_arbiter
// Parameterised round-robin grant. Scans the request vector starting at
// position ptr, wrapping modulo NREQ, and grants the first asserted request.
// Purely combinational; the caller owns and advances the pointer.
// Ports:
//   req   in  NREQ : request vector
//   ptr   in  PW   : index with highest priority this cycle (must be < NREQ)
//   grant out NREQ : one-hot grant, all zero when no request is asserted

module rr_arbiter
    import exu_cordic_arb_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    // One extra bit so ptr+k can exceed NREQ-1 before being folded back.
    logic [PW:0] cand;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!found && req[cand[PW-1:0]]) begin
                grant[cand[PW-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exu_cordic_arb.sv
// exu_cordic_arb
// Shares one CORDIC execution unit among NREQ requesters. Issues one request
// at a time (round-robin), remembers which requester owns the outstanding
// operation, returns the result to it, and turns a unit that never answers
// into an error response after TMO cycles. A result that arrives after the
// watchdog fired is swallowed in DRAIN before the unit is reused.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req_vld/req_rdy          : per-requester issue handshake
//   req_angle/req_rdidx      : packed per-requester operands, slot i at [i*W +: W]
//   rsp_vld/rsp_rdy          : one-hot response valid toward the owner, per-requester accept
//   rsp_data/rsp_rdidx/rsp_err : shared response payload, err marks a watchdog expiry
//   cu_vld/cu_rdy/cu_angle/cu_rdidx : dispatch handshake toward exu_cordic
//   cu_rsp_vld/cu_rsp_rdy/cu_rsp_data : write-back handshake from exu_cordic
//   busy                     : an operation or its clean-up is in progress

module exu_cordic_arb
    import exu_cordic_arb_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int XLEN = DEFAULT_XLEN,
    parameter int RIDX = DEFAULT_RIDX,
    parameter int TMO  = DEFAULT_TMO
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*XLEN-1:0] req_angle,
    input  logic [NREQ*RIDX-1:0] req_rdidx,
    output logic [NREQ-1:0]      rsp_vld,
    input  logic [NREQ-1:0]      rsp_rdy,
    output logic [XLEN-1:0]      rsp_data,
    output logic [RIDX-1:0]      rsp_rdidx,
    output logic                 rsp_err,
    output logic                 cu_vld,
    input  logic                 cu_rdy,
    output logic [XLEN-1:0]      cu_angle,
    output logic [RIDX-1:0]      cu_rdidx,
    input  logic                 cu_rsp_vld,
    output logic                 cu_rsp_rdy,
    input  logic [XLEN-1:0]      cu_rsp_data,
    output logic                 busy
);

    localparam int PW = idx_width(NREQ);
    localparam int TW = idx_width(TMO);

    arb_state_e      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   g_idx;
    logic [NREQ-1:0] grant;
    logic [RIDX-1:0] rdidx_q;
    logic [XLEN-1:0] data_q;
    logic            err_q;
    logic            stale;
    logic [TW-1:0]   timer;
    logic            issue;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req   (req_vld),
        .ptr   (ptr),
        .grant (grant)
    );

    // Turn the one-hot grant into an index and steer that requester's operands.
    always_comb begin
        g_idx    = '0;
        cu_angle = '0;
        cu_rdidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_idx    = PW'(i);
                cu_angle = req_angle[i*XLEN +: XLEN];
                cu_rdidx = req_rdidx[i*RIDX +: RIDX];
            end
        end
    end

    assign cu_vld     = (state == ST_IDLE) && (|req_vld);
    assign req_rdy    = (state == ST_IDLE && cu_rdy) ? grant : '0;
    assign issue      = cu_vld && cu_rdy;
    assign cu_rsp_rdy = (state == ST_WAIT) || (state == ST_DRAIN);
    assign busy       = (state != ST_IDLE);
    assign rsp_vld    = (state == ST_RESP) ? (NREQ'(1) << owner) : '0;
    assign rsp_data   = data_q;
    assign rsp_rdidx  = rdidx_q;
    assign rsp_err    = err_q;

    // Main sequencer. The timer counts the issue cycle as cycle 1, so reaching
    // TMO-1 in WAIT puts the error response on the bus exactly TMO cycles after
    // issue. A real result always beats a coincident timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            owner   <= '0;
            rdidx_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            stale   <= 1'b0;
            timer   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        owner   <= g_idx;
                        rdidx_q <= cu_rdidx;
                        ptr     <= (g_idx == PW'(NREQ-1)) ? '0 : g_idx + 1'b1;
                        timer   <= TW'(1);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                    if (cu_rsp_vld) begin
                        data_q <= cu_rsp_data;
                        err_q  <= 1'b0;
                        state  <= ST_RESP;
                    end else if (timer == TW'(TMO-1)) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                        stale  <= 1'b1;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_rdy[owner]) begin
                        state <= stale ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (cu_rsp_vld) begin
                        stale <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_cordic_arb.sv
// tb_exu_cordic_arb
// Directed bench for exu_cordic_arb with NREQ=2 and TMO=16. The bench plays
// both the requesters and the CORDIC unit. Expected responses are queued when
// an operation is issued and a separate monitor compares them whenever a
// response handshake happens.

module tb_exu_cordic_arb;

    localparam int NREQ = 2;
    localparam int XLEN = 32;
    localparam int RIDX = 5;
    localparam int TMO  = 16;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ-1:0]      req_rdy;
    logic [NREQ*XLEN-1:0] req_angle;
    logic [NREQ*RIDX-1:0] req_rdidx;
    logic [NREQ-1:0]      rsp_vld;
    logic [NREQ-1:0]      rsp_rdy;
    logic [XLEN-1:0]      rsp_data;
    logic [RIDX-1:0]      rsp_rdidx;
    logic                 rsp_err;
    logic                 cu_vld;
    logic                 cu_rdy;
    logic [XLEN-1:0]      cu_angle;
    logic [RIDX-1:0]      cu_rdidx;
    logic                 cu_rsp_vld;
    logic                 cu_rsp_rdy;
    logic [XLEN-1:0]      cu_rsp_data;
    logic                 busy;

    typedef struct {
        logic [NREQ-1:0] vld;
        logic [XLEN-1:0] data;
        logic [RIDX-1:0] rd;
        logic            err;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    exu_cordic_arb #(
        .NREQ (NREQ),
        .XLEN (XLEN),
        .RIDX (RIDX),
        .TMO  (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_angle   (req_angle),
        .req_rdidx   (req_rdidx),
        .rsp_vld     (rsp_vld),
        .rsp_rdy     (rsp_rdy),
        .rsp_data    (rsp_data),
        .rsp_rdidx   (rsp_rdidx),
        .rsp_err     (rsp_err),
        .cu_vld      (cu_vld),
        .cu_rdy      (cu_rdy),
        .cu_angle    (cu_angle),
        .cu_rdidx    (cu_rdidx),
        .cu_rsp_vld  (cu_rsp_vld),
        .cu_rsp_rdy  (cu_rsp_rdy),
        .cu_rsp_data (cu_rsp_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] vld, input logic [31:0] a0, input logic [4:0] r0,
                                 input logic [31:0] a1, input logic [4:0] r1);
        req_vld   = vld;
        req_angle = {a1, a0};
        req_rdidx = {r1, r0};
    endtask

    task automatic pushExp(input logic [1:0] v, input logic [31:0] d, input logic [4:0] r, input logic e);
        exp_t x;
        x.vld  = v;
        x.data = d;
        x.rd   = r;
        x.err  = e;
        expq.push_back(x);
    endtask

    // Wait (bounded) for an issue handshake, check who won and what went to
    // the unit, then step into the first WAIT cycle.
    task automatic waitIssue(input logic [1:0] expGrant, input logic [31:0] expAngle,
                             input logic [4:0] expRd, output int waited);
        for (waited = 0; waited < 30; waited++) begin
            @(negedge clk);
            if (cu_vld && (req_rdy != '0)) break;
        end
        checkOutput("issue_seen", {63'b0, waited < 30}, 64'd1);
        checkOutput("issue_grant", {62'b0, req_rdy}, {62'b0, expGrant});
        checkOutput("issue_angle", {32'b0, cu_angle}, {32'b0, expAngle});
        checkOutput("issue_rdidx", {59'b0, cu_rdidx}, {59'b0, expRd});
        tick();
    endtask

    // Unit answers after 'delay' cycles; returns in the cycle after the answer.
    task automatic respond(input logic [31:0] data, input int delay);
        repeat (delay) tick();
        cu_rsp_vld  = 1'b1;
        cu_rsp_data = data;
        tick();
        cu_rsp_vld  = 1'b0;
        cu_rsp_data = '0;
    endtask

    // Scoreboard monitor: every response handshake consumes one expectation.
    always @(negedge clk) begin
        if (!rst && ((rsp_vld & rsp_rdy) != '0)) begin
            if (expq.size() == 0) begin
                checkOutput("sb_unexpected", {62'b0, rsp_vld}, 64'd0);
            end else begin
                mon_e = expq.pop_front();
                checkOutput("sb_vld", {62'b0, rsp_vld}, {62'b0, mon_e.vld});
                checkOutput("sb_data", {32'b0, rsp_data}, {32'b0, mon_e.data});
                checkOutput("sb_rdidx", {59'b0, rsp_rdidx}, {59'b0, mon_e.rd});
                checkOutput("sb_err", {63'b0, rsp_err}, {63'b0, mon_e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int w;
        int early;
        logic [31:0] cdata [4];
        cdata[0] = 32'h0A000001;
        cdata[1] = 32'h0B000002;
        cdata[2] = 32'h0A000003;
        cdata[3] = 32'h0B000004;

        rst         = 1'b1;
        req_vld     = '0;
        req_angle   = '0;
        req_rdidx   = '0;
        rsp_rdy     = 2'b11;
        cu_rdy      = 1'b1;
        cu_rsp_vld  = 1'b0;
        cu_rsp_data = '0;

        // Reset values
        @(negedge clk);
        checkOutput("rst_req_rdy", {62'b0, req_rdy}, 64'd0);
        checkOutput("rst_rsp_vld", {62'b0, rsp_vld}, 64'd0);
        checkOutput("rst_rsp_data", {32'b0, rsp_data}, 64'd0);
        checkOutput("rst_rsp_rdidx", {59'b0, rsp_rdidx}, 64'd0);
        checkOutput("rst_rsp_err", {63'b0, rsp_err}, 64'd0);
        checkOutput("rst_cu_vld", {63'b0, cu_vld}, 64'd0);
        checkOutput("rst_cu_rsp_rdy", {63'b0, cu_rsp_rdy}, 64'd0);
        checkOutput("rst_busy", {63'b0, busy}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single request from requester 0
        $display("[TB] single request");
        applyStimulus(2'b01, 32'h00000000, 5'd7, 32'h0, 5'd0);
        pushExp(2'b01, 32'h40000000, 5'd7, 1'b0);
        waitIssue(2'b01, 32'h00000000, 5'd7, w);
        checkOutput("single_issue_lat", 64'(w), 64'd0);
        req_vld = '0;
        @(negedge clk);
        checkOutput("single_busy", {63'b0, busy}, 64'd1);
        checkOutput("single_cu_rsp_rdy", {63'b0, cu_rsp_rdy}, 64'd1);
        tick();
        respond(32'h40000000, 1);
        @(negedge clk);
        checkOutput("single_rsp_vld", {62'b0, rsp_vld}, 64'h1);
        tick();

        // Backpressure on requester 1 while requester 0 waits
        $display("[TB] backpressure");
        applyStimulus(2'b10, 32'h0, 5'd0, 32'h12340000, 5'd12);
        pushExp(2'b10, 32'h12345678, 5'd12, 1'b0);
        waitIssue(2'b10, 32'h12340000, 5'd12, w);
        req_vld = '0;
        rsp_rdy = 2'b01;
        respond(32'h12345678, 3);
        applyStimulus(2'b01, 32'h55550000, 5'd4, 32'h0, 5'd0);
        pushExp(2'b01, 32'h55AA55AA, 5'd4, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("bp_rsp_vld", {62'b0, rsp_vld}, 64'h2);
            checkOutput("bp_rsp_data", {32'b0, rsp_data}, 64'h12345678);
            checkOutput("bp_rsp_rdidx", {59'b0, rsp_rdidx}, 64'd12);
            checkOutput("bp_cu_rsp_rdy", {63'b0, cu_rsp_rdy}, 64'd0);
            checkOutput("bp_req_rdy", {62'b0, req_rdy}, 64'd0);
            tick();
        end
        rsp_rdy = 2'b11;
        tick();
        waitIssue(2'b01, 32'h55550000, 5'd4, w);
        checkOutput("bp_next_issue_b2b", 64'(w), 64'd0);
        req_vld = '0;
        respond(32'h55AA55AA, 1);
        @(negedge clk);
        checkOutput("bp_req0_rsp_vld", {62'b0, rsp_vld}, 64'h1);
        tick();

        // Watchdog: unit never answers in time
        $display("[TB] watchdog");
        applyStimulus(2'b01, 32'h33330000, 5'd21, 32'h0, 5'd0);
        pushExp(2'b01, 32'h0, 5'd21, 1'b1);
        waitIssue(2'b01, 32'h33330000, 5'd21, w);
        req_vld = '0;
        early = 0;
        repeat (TMO - 1) begin
            @(negedge clk);
            if (rsp_vld != '0) early++;
            tick();
        end
        checkOutput("wd_early_rsp", 64'(early), 64'd0);
        @(negedge clk);
        checkOutput("wd_rsp_vld", {62'b0, rsp_vld}, 64'h1);
        checkOutput("wd_rsp_err", {63'b0, rsp_err}, 64'd1);
        checkOutput("wd_rsp_data", {32'b0, rsp_data}, 64'd0);
        applyStimulus(2'b01, 32'h44440000, 5'd22, 32'h0, 5'd0);
        tick();
        @(negedge clk);
        checkOutput("drain_busy", {63'b0, busy}, 64'd1);
        checkOutput("drain_cu_rsp_rdy", {63'b0, cu_rsp_rdy}, 64'd1);
        checkOutput("drain_cu_vld", {63'b0, cu_vld}, 64'd0);
        checkOutput("drain_req_rdy", {62'b0, req_rdy}, 64'd0);
        tick();
        pushExp(2'b01, 32'h600DF00D, 5'd22, 1'b0);
        respond(32'hDEADBEEF, 0);
        waitIssue(2'b01, 32'h44440000, 5'd22, w);
        checkOutput("drain_exit_issue", 64'(w), 64'd0);
        req_vld = '0;
        respond(32'h600DF00D, 2);
        @(negedge clk);
        checkOutput("after_wd_rsp_vld", {62'b0, rsp_vld}, 64'h1);
        checkOutput("after_wd_rsp_err", {63'b0, rsp_err}, 64'd0);
        tick();

        // Response coincides with the last watchdog cycle
        $display("[TB] coincident");
        applyStimulus(2'b10, 32'h0, 5'd0, 32'h66660000, 5'd5);
        pushExp(2'b10, 32'h7FFF0001, 5'd5, 1'b0);
        waitIssue(2'b10, 32'h66660000, 5'd5, w);
        req_vld = '0;
        respond(32'h7FFF0001, TMO - 2);
        @(negedge clk);
        checkOutput("coin_rsp_vld", {62'b0, rsp_vld}, 64'h2);
        checkOutput("coin_rsp_err", {63'b0, rsp_err}, 64'd0);
        checkOutput("coin_rsp_data", {32'b0, rsp_data}, 64'h7FFF0001);
        tick();
        @(negedge clk);
        checkOutput("coin_no_drain", {63'b0, busy}, 64'd0);
        tick();

        // Reset while waiting on the unit
        $display("[TB] reset in WAIT");
        applyStimulus(2'b01, 32'h77770000, 5'd8, 32'h0, 5'd0);
        waitIssue(2'b01, 32'h77770000, 5'd8, w);
        req_vld = '0;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rstw_busy", {63'b0, busy}, 64'd0);
        checkOutput("rstw_cu_rsp_rdy", {63'b0, cu_rsp_rdy}, 64'd0);
        checkOutput("rstw_rsp_vld", {62'b0, rsp_vld}, 64'd0);
        checkOutput("rstw_rsp_err", {63'b0, rsp_err}, 64'd0);
        checkOutput("rstw_rsp_data", {32'b0, rsp_data}, 64'd0);
        checkOutput("rstw_rsp_rdidx", {59'b0, rsp_rdidx}, 64'd0);
        tick();
        rst = 1'b0;

        // Contention right after reset: pointer restarts at requester 0
        $display("[TB] contention");
        applyStimulus(2'b11, 32'h11110000, 5'd3, 32'h22220000, 5'd9);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] g;
            g = (k % 2 == 1) ? 2'b10 : 2'b01;
            pushExp(g, cdata[k], (k % 2 == 1) ? 5'd9 : 5'd3, 1'b0);
            waitIssue(g, (k % 2 == 1) ? 32'h22220000 : 32'h11110000,
                      (k % 2 == 1) ? 5'd9 : 5'd3, w);
            checkOutput("cont_issue_b2b", 64'(w), 64'd0);
            respond(cdata[k], 1);
            @(negedge clk);
            checkOutput("cont_rsp_vld", {62'b0, rsp_vld}, {62'b0, g});
            tick();
        end
        req_vld = '0;

        repeat (3) tick();
        checkOutput("sb_all_consumed", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
